// File: rtl/note_event_sequencer.sv
// Note event sequencer: walks a time-stamped chart ROM in order and issues one
// key event per entry over valid/ready once the song timer reaches its timestamp.
module note_event_sequencer #(
  parameter int unsigned TIMEBITS = 29,
  parameter int unsigned KEYBITS  = 4,
  parameter int unsigned ADDRBITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [TIMEBITS-1:0]       microSecondCounter,
  output logic [ADDRBITS-1:0]       romAddr,
  input  logic [TIMEBITS+KEYBITS:0] romData,
  output logic                      noteValid,
  input  logic                      noteReady,
  output logic [KEYBITS-1:0]        noteKey,
  output logic [TIMEBITS-1:0]       noteTime,
  output logic                      busy,
  output logic                      songDone
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StWaitTime, StEmit, StDone
  } state_e;

  localparam logic [ADDRBITS-1:0] LastAddr = '1;

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] rom_addr_q, rom_addr_d;
  logic [KEYBITS-1:0]  note_key_q, note_key_d;
  logic [TIMEBITS-1:0] note_time_q, note_time_d;
  logic [TIMEBITS-1:0] prev_time_q;
  logic                entry_end_q, entry_end_d;
  logic [TIMEBITS-1:0] entry_time_q, entry_time_d;
  logic [KEYBITS-1:0]  entry_key_q, entry_key_d;

  logic                rom_end;
  logic [TIMEBITS-1:0] rom_time;
  logic [KEYBITS-1:0]  rom_key;
  logic                handshake;
  logic                timer_wrapped;
  logic                entry_due;

  assign rom_end       = romData[TIMEBITS+KEYBITS];
  assign rom_time      = romData[TIMEBITS+KEYBITS-1:KEYBITS];
  assign rom_key       = romData[KEYBITS-1:0];
  assign handshake     = (state_q == StEmit) && noteReady;
  // A count below last cycle's value means the timer rolled over.
  assign timer_wrapped = microSecondCounter < prev_time_q;
  assign entry_due     = microSecondCounter >= entry_time_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rom_addr_q   <= '0;
      note_key_q   <= '0;
      note_time_q  <= '0;
      prev_time_q  <= '0;
      entry_end_q  <= 1'b0;
      entry_time_q <= '0;
      entry_key_q  <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      note_key_q   <= note_key_d;
      note_time_q  <= note_time_d;
      prev_time_q  <= microSecondCounter;
      entry_end_q  <= entry_end_d;
      entry_time_q <= entry_time_d;
      entry_key_q  <= entry_key_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    note_key_d   = note_key_q;
    note_time_d  = note_time_q;
    entry_end_d  = entry_end_q;
    entry_time_d = entry_time_q;
    entry_key_d  = entry_key_q;
    unique case (state_q)
      StIdle: begin
        rom_addr_d = '0;
        if (start) state_d = StFetch;
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        entry_end_d  = rom_end;
        entry_time_d = rom_time;
        entry_key_d  = rom_key;
        state_d      = rom_end ? StDone : StWaitTime;
      end
      StWaitTime: begin
        if (timer_wrapped) begin
          state_d = StDone;
        end else if (entry_due) begin
          note_key_d  = entry_key_q;
          note_time_d = entry_time_q;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        // Wrap is deliberately ignored here so an accepted-pending event is never lost.
        if (handshake) begin
          if (rom_addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        if (start) begin
          rom_addr_d = '0;
          state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    romAddr   = rom_addr_q;
    noteKey   = note_key_q;
    noteTime  = note_time_q;
    noteValid = (state_q == StEmit);
    songDone  = (state_q == StDone);
    busy      = (state_q != StIdle) && (state_q != StDone);
  end

endmodule

// File: tb/tb_note_event_sequencer.sv
// Bench for note_event_sequencer: scoreboarded event stream plus per-scenario
// checks of timing, backpressure, wrap, address exhaustion and reset abort.
module tb_note_event_sequencer;
  localparam int unsigned TB = 29;
  localparam int unsigned KB = 4;
  localparam int unsigned AB = 2;
  localparam int unsigned WB = TB + KB + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [TB-1:0] us_cnt;
  logic [AB-1:0] romAddr;
  logic [WB-1:0] romData;
  logic          noteValid;
  logic          noteReady;
  logic [KB-1:0] noteKey;
  logic [TB-1:0] noteTime;
  logic          busy;
  logic          songDone;

  logic [WB-1:0]    rom [4];
  logic [KB+TB-1:0] exp_q [$];
  logic [KB+TB-1:0] exp_v;
  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;

  note_event_sequencer #(
    .TIMEBITS(TB),
    .KEYBITS (KB),
    .ADDRBITS(AB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .microSecondCounter(us_cnt),
    .romAddr           (romAddr),
    .romData           (romData),
    .noteValid         (noteValid),
    .noteReady         (noteReady),
    .noteKey           (noteKey),
    .noteTime          (noteTime),
    .busy              (busy),
    .songDone          (songDone)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) romData <= rom[romAddr];

  // Scoreboard: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && noteValid && noteReady) begin
      hs_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got key=%0d time=%0d, required no event",
                 noteKey, noteTime);
      end else begin
        exp_v = exp_q.pop_front();
        if ({noteKey, noteTime} !== exp_v) begin
          miscompares++;
          $display("FAIL event: got key=%0d time=%0d, required key=%0d time=%0d",
                   noteKey, noteTime, exp_v[KB+TB-1:TB], exp_v[TB-1:0]);
        end
      end
    end
  end

  function automatic logic [WB-1:0] mk(input logic e, input logic [TB-1:0] t,
                                       input logic [KB-1:0] k);
    return {e, t, k};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({romAddr, noteKey, noteTime, noteValid, busy, songDone} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got addr=%0d key=%0d time=%0d v=%b b=%b d=%b, required all 0",
               romAddr, noteKey, noteTime, noteValid, busy, songDone);
    end
    reset = 1'b0;
    repeat (3) step();
    vectors++;
    if ({noteValid, busy, songDone, romAddr} !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got v=%b b=%b d=%b addr=%0d, required 0",
               noteValid, busy, songDone, romAddr);
    end
  endtask

  task automatic test_basic();
    int  rises[$];
    logic prev_v = 1'b0;
    rom[0] = mk(1'b0, 29'd10, 4'd3);
    rom[1] = mk(1'b0, 29'd25, 4'd7);
    rom[2] = mk(1'b1, 29'd0, 4'd0);
    noteReady = 1'b1;
    us_cnt = '0;
    exp_q.push_back({4'd3, 29'd10});
    exp_q.push_back({4'd7, 29'd25});
    pulse_start();
    for (int i = 0; i < 80 && !songDone; i++) begin
      us_cnt = us_cnt + 1'b1;
      step();
      // us_cnt still holds the count seen by the edge that was just taken.
      if (noteValid && !prev_v) rises.push_back(int'(us_cnt));
      prev_v = noteValid;
    end
    vectors++;
    if (!songDone || romAddr !== 2'd2) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b addr=%0d, required done=1 addr=2",
               songDone, romAddr);
    end
    vectors++;
    if (rises.size() != 2) begin
      miscompares++;
      $display("FAIL basic_rise_count: got %0d, required 2", rises.size());
    end else if (rises[0] != 10 || rises[1] != 25) begin
      miscompares++;
      $display("FAIL basic_rise_time: got %0d,%0d, required 10,25", rises[0], rises[1]);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int base = hs_count;
    rom[0] = mk(1'b0, 29'd5, 4'd2);
    rom[1] = mk(1'b1, 29'd0, 4'd0);
    noteReady = 1'b0;
    us_cnt = 29'd100;
    exp_q.push_back({4'd2, 29'd5});
    pulse_start();
    for (int i = 0; i < 20 && !noteValid; i++) step();
    vectors++;
    if (!noteValid) begin
      miscompares++;
      $display("FAIL bp_valid_timeout: got valid=0, required 1 within 20 cycles");
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (!noteValid || noteKey !== 4'd2 || noteTime !== 29'd5 || romAddr !== 2'd0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b key=%0d time=%0d addr=%0d, required 1/2/5/0",
                 i, noteValid, noteKey, noteTime, romAddr);
      end
      step();
    end
    noteReady = 1'b1;
    step();
    vectors++;
    if (noteValid || romAddr !== 2'd1) begin
      miscompares++;
      $display("FAIL bp_accept: got v=%b addr=%0d, required v=0 addr=1", noteValid, romAddr);
    end
    for (int i = 0; i < 10 && !songDone; i++) step();
    vectors++;
    if (!songDone || romAddr !== 2'd1 || hs_count - base != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_single: got done=%b addr=%0d hs=%0d, required done=1 addr=1 hs=1",
               songDone, romAddr, hs_count - base);
    end
  endtask

  task automatic test_late_equal();
    int valid_at[$];
    rom[0] = mk(1'b0, 29'd0, 4'd1);
    rom[1] = mk(1'b0, 29'd0, 4'd4);
    rom[2] = mk(1'b1, 29'd0, 4'd0);
    noteReady = 1'b1;
    us_cnt = 29'd100;
    exp_q.push_back({4'd1, 29'd0});
    exp_q.push_back({4'd4, 29'd0});
    pulse_start();
    for (int i = 1; i < 30 && !songDone; i++) begin
      step();
      if (noteValid) valid_at.push_back(i);
    end
    vectors++;
    if (valid_at.size() != 2) begin
      miscompares++;
      $display("FAIL late_count: got %0d events, required 2", valid_at.size());
    end else if (valid_at[0] != 3 || valid_at[1] - valid_at[0] != 4) begin
      miscompares++;
      $display("FAIL late_spacing: got first=%0d gap=%0d, required first=3 gap=4",
               valid_at[0], valid_at[1] - valid_at[0]);
    end
    vectors++;
    if (!songDone || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL late_done: got done=%b pending=%0d, required 1/0", songDone, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int   base = hs_count;
    logic seen_v = 1'b0;
    rom[0] = mk(1'b0, 29'd500, 4'd6);
    rom[1] = mk(1'b1, 29'd0, 4'd0);
    noteReady = 1'b1;
    us_cnt = 29'd200;
    pulse_start();
    repeat (6) begin
      step();
      seen_v |= noteValid;
    end
    vectors++;
    if (!busy || songDone) begin
      miscompares++;
      $display("FAIL wrap_waiting: got busy=%b done=%b, required 1/0", busy, songDone);
    end
    us_cnt = '0;
    step();
    seen_v |= noteValid;
    vectors++;
    if (!songDone || busy) begin
      miscompares++;
      $display("FAIL wrap_done: got done=%b busy=%b, required 1/0", songDone, busy);
    end
    vectors++;
    if (seen_v || hs_count != base || romAddr !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_no_event: got seen=%b hs=%0d addr=%0d, required 0/0/0",
               seen_v, hs_count - base, romAddr);
    end
  endtask

  task automatic test_exhaust();
    for (int i = 0; i < 4; i++) rom[i] = mk(1'b0, 29'd0, KB'(8 + i));
    noteReady = 1'b1;
    us_cnt = 29'd50;
    for (int pass = 0; pass < 2; pass++) begin
      int base = hs_count;
      for (int i = 0; i < 4; i++) exp_q.push_back({KB'(8 + i), 29'd0});
      pulse_start();
      vectors++;
      if (romAddr !== 2'd0 || !busy) begin
        miscompares++;
        $display("FAIL exh_start[%0d]: got addr=%0d busy=%b, required 0/1", pass, romAddr, busy);
      end
      for (int i = 0; i < 40 && !songDone; i++) step();
      vectors++;
      if (!songDone || romAddr !== 2'd3 || hs_count - base != 4 || exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL exh_done[%0d]: got done=%b addr=%0d hs=%0d, required 1/3/4",
                 pass, songDone, romAddr, hs_count - base);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int   base = hs_count;
    logic any_out = 1'b0;
    rom[0] = mk(1'b0, 29'd0, 4'd5);
    rom[1] = mk(1'b0, 29'd60, 4'd6);
    rom[2] = mk(1'b1, 29'd0, 4'd0);
    rom[3] = mk(1'b1, 29'd0, 4'd0);
    noteReady = 1'b1;
    us_cnt = 29'd50;
    exp_q.push_back({4'd5, 29'd0});
    pulse_start();
    for (int i = 0; i < 20 && hs_count == base; i++) step();
    noteReady = 1'b0;
    us_cnt = 29'd70;
    for (int i = 0; i < 20 && !noteValid; i++) step();
    vectors++;
    if (!noteValid || romAddr !== 2'd1 || noteKey !== 4'd6) begin
      miscompares++;
      $display("FAIL rst_pre: got v=%b addr=%0d key=%0d, required 1/1/6",
               noteValid, romAddr, noteKey);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({noteValid, busy, songDone, romAddr, noteKey, noteTime} !== '0) begin
      miscompares++;
      $display("FAIL rst_abort: got v=%b b=%b d=%b addr=%0d key=%0d time=%0d, required 0",
               noteValid, busy, songDone, romAddr, noteKey, noteTime);
    end
    step();
    reset = 1'b0;
    noteReady = 1'b1;
    repeat (10) begin
      step();
      any_out |= noteValid | busy | songDone;
    end
    vectors++;
    if (any_out || hs_count - base != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_idle: got activity=%b hs=%0d, required 0/1", any_out, hs_count - base);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = '0;
    reset = 1'b1;
    start = 1'b0;
    noteReady = 1'b0;
    us_cnt = '0;
    repeat (3) step();
    test_reset();
    test_basic();
    test_backpressure();
    test_late_equal();
    test_wrap();
    test_exhaust();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
